dmem_stage: RTL and testbench

- MEM-stage data-memory unit for the 16-bit five-stage pipeline. Sits between EX/MEM and MEM/WB and replaces the stubbed data-cache hookup.
- Serves loads (opcode 0xb) and stores from a direct-mapped, write-through, no-write-allocate cache with single-word lines.
- Misses and all writes go to a backing memory over a req/ack handshake. The block stalls the pipeline while that traffic is in flight.

---
 rtl/dmem_stage.sv | 147 ++++++++++++++
 tb/tb_dmem_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// MEM-stage data memory: direct-mapped, write-through, no-write-allocate cache
// with single-word lines, backed by a req/ack memory port.
module dmem_stage #(
  parameter int LINES  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [DATA_W-1:0] rd_out,
  output logic              rd_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int TAG_W = DATA_W - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [TAG_W-1:0]    tag_d  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];
  logic [DATA_W-1:0]   data_d [LINES];
  logic [DATA_W-1:0]   rd_out_q, rd_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;

  assign idx = addr[IDX_W-1:0];
  assign tag = addr[DATA_W-1:IDX_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    rd_out_d    = rd_out_q;
    rd_valid_d  = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        stall = wr_en | (rd_en & ~hit);
        // A simultaneous read+write is a store only.
        if (wr_en) begin
          state_d     = WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = wr_data;
        end else if (rd_en) begin
          if (hit) begin
            rd_out_d   = data_q[idx];
            rd_valid_d = 1'b1;
          end else begin
            state_d    = RD_MISS;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr;
          end
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem_ack && mem_req_q) begin
          valid_d[idx] = 1'b1;
          tag_d[idx]   = tag;
          data_d[idx]  = mem_rdata;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      WR_THRU: begin
        stall = 1'b1;
        if (mem_ack && mem_req_q) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (wr_en && hit) begin
          data_d[idx] = wr_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      rd_out_q    <= '0;
      rd_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rd_out_q    <= rd_out_d;
      rd_valid_q  <= rd_valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_out    = rd_out_q;
  assign rd_valid  = rd_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage; backing memory acks 2 cycles after mem_req rises.
module tb_dmem_stage;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        stall;
  logic [15:0] rd_out;
  logic        rd_valid;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic [15:0] model [256];
  int          n_checks;
  int          n_fail;
  int          ns;
  int          nr;

  dmem_stage #(.LINES(8), .IDX_W(3), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .stall     (stall),
    .rd_out    (rd_out),
    .rd_valid  (rd_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and plays the backing memory until it is accepted.
  task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, output int nstall, output int nreq);
    int   age;
    logic done;
    logic acked;
    rd_en   = rd;
    wr_en   = wr;
    addr    = a;
    wr_data = wd;
    nstall  = 0;
    nreq    = 0;
    age     = 0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      #1;
      acked = 1'b0;
      if (mem_req) begin
        nreq++;
        age++;
        if (age == 1) begin
          check_eq("mem_addr", mem_addr, a);
          check_eq("mem_we", 16'(mem_we), 16'(wr));
          if (wr) check_eq("mem_wdata", mem_wdata, wd);
        end
        if (age == 3) begin
          mem_ack   = 1'b1;
          mem_rdata = model[a[7:0]];
          acked     = 1'b1;
        end
      end
      if (stall) nstall++;
      else done = 1'b1;
      tick();
      mem_ack = 1'b0;
      if (acked) begin
        check_eq("req_drop", 16'(mem_req), 16'h0);
        if (wr) model[a[7:0]] = wd;
      end
    end
    check_eq("accepted", 16'(done), 16'h1);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input int exp_stall,
                          input logic [15:0] exp_data);
    xact(1'b1, 1'b0, a, 16'h0, ns, nr);
    check_eq({tag, "_stall"}, 16'(ns), 16'(exp_stall));
    check_eq({tag, "_req"}, 16'(nr), (exp_stall == 0) ? 16'd0 : 16'd3);
    check_eq({tag, "_valid"}, 16'(rd_valid), 16'h1);
    check_eq({tag, "_data"}, rd_out, exp_data);
    tick();
    check_eq({tag, "_pulse"}, 16'(rd_valid), 16'h0);
  endtask

  task automatic write_chk(input string tag, input logic rd, input logic [15:0] a,
                           input logic [15:0] d);
    xact(rd, 1'b1, a, d, ns, nr);
    check_eq({tag, "_stall"}, 16'(ns), 16'd4);
    check_eq({tag, "_req"}, 16'(nr), 16'd3);
    check_eq({tag, "_novalid"}, 16'(rd_valid), 16'h0);
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    addr      = '0;
    wr_data   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) model[i] = 16'(i * 3 + 16'h0100);
    model[8'h13] = 16'hBEEF;
    model[8'h1B] = 16'hCAFE;
    model[8'h40] = 16'h0777;
    model[8'h0B] = 16'h0B0B;

    tick();
    tick();
    check_eq("rst_rd_out", rd_out, 16'h0);
    check_eq("rst_rd_valid", 16'(rd_valid), 16'h0);
    check_eq("rst_mem_req", 16'(mem_req), 16'h0);
    check_eq("rst_mem_we", 16'(mem_we), 16'h0);
    check_eq("rst_mem_addr", mem_addr, 16'h0);
    check_eq("rst_mem_wdata", mem_wdata, 16'h0);
    check_eq("rst_stall", 16'(stall), 16'h0);
    rst = 1'b0;
    tick();

    read_chk("cold", 16'h0013, 4, 16'hBEEF);
    read_chk("reread", 16'h0013, 0, 16'hBEEF);
    read_chk("conflict", 16'h001B, 4, 16'hCAFE);
    read_chk("evicted", 16'h0013, 4, 16'hBEEF);

    write_chk("wr_hit", 1'b0, 16'h0013, 16'h1234);
    read_chk("wr_hit_rd", 16'h0013, 0, 16'h1234);

    write_chk("wr_miss", 1'b0, 16'h0040, 16'h5555);
    read_chk("wr_miss_rd", 16'h0040, 4, 16'h5555);

    write_chk("rdwr", 1'b1, 16'h0013, 16'h4321);
    read_chk("rdwr_rd", 16'h0013, 0, 16'h4321);

    // Reset while a read miss waits for its ack, then a stray late ack.
    rd_en = 1'b1;
    addr  = 16'h000B;
    tick();
    check_eq("mid_req", 16'(mem_req), 16'h1);
    rst   = 1'b1;
    rd_en = 1'b0;
    tick();
    check_eq("mid_rst_req", 16'(mem_req), 16'h0);
    check_eq("mid_rst_stall", 16'(stall), 16'h0);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check_eq("late_ack_req", 16'(mem_req), 16'h0);
    tick();
    read_chk("after_rst", 16'h000B, 4, 16'h0B0B);
    read_chk("after_rst_old", 16'h0040, 4, 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
